data_cache_controller: RTL and testbench
========================================

// Module: data_cache_controller
// PURPOSE
//  2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and sram_controller.
//  Read hits complete in the same cycle without touching SRAM.
//  Read misses fetch one word through sram_controller and fill the cache.
//  All writes go to SRAM; a write hit also updates the cached copy.
// PARAMETERS
//  SETS      64     number of sets (power of 2); INDEX_W = log2(SETS)
//  TAG_W     10     tag width; word address = INDEX_W + TAG_W bits (16 by default)
//  ADDR_BASE 1024   byte address of the first data-memory word
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  rd_en        in   1   MEM-stage read request; held high until ready
//  wr_en        in   1   MEM-stage write request; held high until ready
//  address      in   32  byte address, word aligned, >= ADDR_BASE
//  write_data   in   32  store data
//  read_data    out  32  load data; valid while ready=1 for a read
//  ready        out  1   request complete this cycle (1-cycle pulse per request)
//  sram_rd_en   out  1   read request to sram_controller
//  sram_wr_en   out  1   write request to sram_controller
//  sram_address out  32  byte address to sram_controller (= address)
//  sram_wdata   out  32  write data to sram_controller (= write_data)
//  sram_rdata   in   32  read data from sram_controller; valid when sram_ready=1
//  sram_ready   in   1   sram_controller done (1-cycle pulse)
// BEHAVIOUR
//  Address split: waddr = (address - ADDR_BASE) >> 2; index = waddr[INDEX_W-1:0];
//   tag = waddr[INDEX_W+TAG_W-1:INDEX_W]. Upper address bits are ignored.
//  Storage per set: 2 ways x {valid, tag, data[31:0]} plus 1 LRU bit.
//   LRU=0 means way0 is least recently used.
//  hit = rd/wr request and a valid way whose tag matches; combinational on address.
//  FSM states IDLE, RD_MISS, WR:
//   IDLE, rd_en & hit:
//    ready=1 and read_data = way data (combinational); LRU <= other way; stay IDLE.
//   IDLE, rd_en & !hit: go to RD_MISS.
//   IDLE, wr_en (and not rd_en):
//    on a hit, write that way's data and set LRU <= other way at this edge; go to WR.
//   rd_en and wr_en both high: rd_en wins; wr_en is ignored.
//   RD_MISS:
//    sram_rd_en=1. Stay until sram_ready.
//    On sram_ready: ready=1, read_data=sram_rdata.
//    Victim way: invalid way0, else invalid way1, else way[LRU].
//    Victim gets {1, tag, sram_rdata}; LRU <= other way; go to IDLE.
//   WR:
//    sram_wr_en=1. Stay until sram_ready.
//    On sram_ready: ready=1; go to IDLE. No allocate on a miss.
//  sram_rd_en/sram_wr_en are combinational from state.
//   They drop in the cycle after sram_ready, so sram_controller (back in idle) does not restart.
//  ready=0 in every other case; read_data=0 when not a read-ready cycle.
//  Latency:
//   read hit 0 extra cycles (ready same cycle as request);
//   read miss / write = 1 + sram_controller latency (~6 cycles).
//  Requester must hold address, write_data and enables stable until ready.
//   A new request may arrive the cycle after ready.
//  Reset (any state, including mid-miss):
//   state=IDLE; all valid=0; all LRU=0; sram_rd_en=sram_wr_en=0; ready=0.
//   Tags and data need not reset.
//   sram_controller shares rst, so no half-finished SRAM access survives.
//  No enable: stay in IDLE and assert nothing.
// TESTING
//  1. Reset, rd 1024 (SRAM=0xA5A5_0001):
//     miss, sram_rd_en until sram_ready; ready with 0xA5A5_0001.
//     Re-read 1024: ready same cycle, sram_rd_en=0.
//  2. Reads of 1024, 1280, 1536 (all index 0, tags 0/1/2):
//     third read evicts tag0. Re-read 1280 hits; re-read 1024 misses.
//  3. Write 0x1234_5678 to 1024 after caching it:
//     sram_wr_en pulses through to sram_ready.
//     Next read of 1024 hits and returns 0x1234_5678.
//  4. Write to uncached 2048, then read 2048:
//     write does not allocate; read misses and returns the SRAM value.
//  5. Assert rst during RD_MISS: sram_rd_en=0 and ready=0 next cycle.
//     Subsequent read of a previously cached address misses.
//  6. rd_en and wr_en both high on a hit: treated as a read hit.
//     No SRAM write, ready same cycle.

Source files
------------

// File: rtl/data_cache_controller.sv
// data_cache_controller
//   2-way set-associative, write-through, no-write-allocate data cache between
//   the MEM stage and sram_controller. Read hits complete in the request cycle;
//   read misses fetch one word through sram_controller and fill a way; every
//   write goes to SRAM, and a write hit also refreshes the cached copy.
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   rd_en, wr_en             MEM-stage requests, held until ready (rd_en wins)
//   address, write_data      byte address (word aligned, >= ADDR_BASE), store data
//   read_data, ready         load data and 1-cycle completion pulse
//   sram_rd_en, sram_wr_en   requests to sram_controller (decoded from state)
//   sram_address, sram_wdata pass-through of address / write_data
//   sram_rdata, sram_ready   sram_controller read data and completion pulse
module data_cache_controller #(
  parameter int unsigned SETS      = 64,
  parameter int unsigned TAG_W     = 10,
  parameter int unsigned ADDR_BASE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int unsigned INDEX_W = $clog2(SETS);
  localparam int unsigned TAG_LO  = INDEX_W + 2;
  localparam int unsigned TAG_HI  = INDEX_W + TAG_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_MISS = 2'd1,
    S_WR      = 2'd2
  } state_t;

  state_t r_state;

  logic [SETS-1:0]  r_valid0;
  logic [SETS-1:0]  r_valid1;
  logic [SETS-1:0]  r_lru;
  logic [TAG_W-1:0] r_tag0  [SETS];
  logic [TAG_W-1:0] r_tag1  [SETS];
  logic [31:0]      r_data0 [SETS];
  logic [31:0]      r_data1 [SETS];

  logic [31:0]        w_off;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_hit_way;
  logic [31:0]        w_hit_data;
  logic               w_victim;
  logic               w_fill;
  logic               w_wr_hit;
  logic               w_rd_hit;
  logic               w_unused_addr_bits;

  // Address split relative to the data-memory base; bits above the tag are ignored
  assign w_off   = address - 32'(ADDR_BASE);
  assign w_index = w_off[TAG_LO-1:2];
  assign w_tag   = w_off[TAG_HI:TAG_LO];
  assign w_unused_addr_bits = ^{w_off[31:TAG_HI+1], w_off[1:0]};

  // Tag compare on the current request address
  assign w_hit0     = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
  assign w_hit1     = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
  assign w_hit      = (rd_en || wr_en) && (w_hit0 || w_hit1);
  assign w_hit_way  = !w_hit0;
  assign w_hit_data = w_hit0 ? r_data0[w_index] : r_data1[w_index];

  // Fill victim: an empty way first, otherwise the least recently used one
  assign w_victim = !r_valid0[w_index] ? 1'b0 :
                    !r_valid1[w_index] ? 1'b1 : r_lru[w_index];

  assign w_rd_hit = (r_state == S_IDLE) && rd_en && w_hit;
  assign w_wr_hit = (r_state == S_IDLE) && !rd_en && wr_en && w_hit;
  assign w_fill   = (r_state == S_RD_MISS) && sram_ready;

  // Completion and load data are combinational so read hits finish in-cycle
  assign ready = w_rd_hit ||
                 (((r_state == S_RD_MISS) || (r_state == S_WR)) && sram_ready);
  assign read_data = w_rd_hit ? w_hit_data :
                     w_fill   ? sram_rdata : 32'd0;

  // SRAM requests follow the state, so they drop the cycle after sram_ready
  assign sram_rd_en   = (r_state == S_RD_MISS);
  assign sram_wr_en   = (r_state == S_WR);
  assign sram_address = address;
  assign sram_wdata   = write_data;

  // Control FSM together with the valid and LRU bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rd_en) begin
            if (w_hit) r_lru[w_index] <= !w_hit_way;
            else       r_state        <= S_RD_MISS;
          end else if (wr_en) begin
            if (w_hit) r_lru[w_index] <= !w_hit_way;
            r_state <= S_WR;
          end
        end
        S_RD_MISS: begin
          if (sram_ready) begin
            if (w_victim) r_valid1[w_index] <= 1'b1;
            else          r_valid0[w_index] <= 1'b1;
            r_lru[w_index] <= !w_victim;
            r_state        <= S_IDLE;
          end
        end
        S_WR: begin
          if (sram_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data storage; contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        if (w_victim) begin
          r_tag1[w_index]  <= w_tag;
          r_data1[w_index] <= sram_rdata;
        end else begin
          r_tag0[w_index]  <= w_tag;
          r_data0[w_index] <= sram_rdata;
        end
      end else if (w_wr_hit) begin
        if (w_hit_way) r_data1[w_index] <= write_data;
        else           r_data0[w_index] <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// tb_data_cache_controller
//   Randomized and directed stimulus for data_cache_controller against a
//   behavioural model: a word memory plus, per set, an MRU-ordered list of at
//   most two tags. A small sram_controller stand-in answers SRAM requests.
module tb_data_cache_controller;

  localparam int SRAM_LAT = 3;
  localparam int MISS_CYC = 3 + SRAM_LAT;
  localparam int MEM_WORDS = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = 32'd1024;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'd0;
  logic        sram_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sram_mem [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  int m_cnt [64];
  int m_t0  [64];
  int m_t1  [64];

  logic s_busy = 1'b0;
  int   s_cnt  = 0;

  data_cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .ready        (ready),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  always #5 clk = ~clk;

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) & 32'h0000_FFFF);
  endfunction

  // sram_controller stand-in: fixed latency, one-cycle ready pulse
  always @(posedge clk) begin
    if (rst) begin
      s_busy     <= 1'b0;
      s_cnt      <= 0;
      sram_ready <= 1'b0;
    end else if (sram_ready) begin
      sram_ready <= 1'b0;
      s_busy     <= 1'b0;
    end else if (!s_busy) begin
      if (sram_rd_en || sram_wr_en) begin
        s_busy <= 1'b1;
        s_cnt  <= SRAM_LAT;
      end
    end else if (s_cnt == 0) begin
      sram_ready <= 1'b1;
      sram_rdata <= sram_mem[word_of(sram_address)];
      if (sram_wr_en) sram_mem[word_of(sram_address)] <= sram_wdata;
    end else begin
      s_cnt <= s_cnt - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(input int s, input int t);
    return (m_cnt[s] >= 1 && m_t0[s] == t) || (m_cnt[s] == 2 && m_t1[s] == t);
  endfunction

  // Move a tag to the MRU slot, inserting it (and dropping the LRU) if absent
  function automatic void m_touch(input int s, input int t);
    if (m_cnt[s] >= 1 && m_t0[s] == t) return;
    if (m_cnt[s] == 2 && m_t1[s] == t) begin
      m_t1[s] = m_t0[s];
      m_t0[s] = t;
      return;
    end
    m_t1[s] = m_t0[s];
    m_t0[s] = t;
    if (m_cnt[s] < 2) m_cnt[s]++;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 64; i++) m_cnt[i] = 0;
  endfunction

  // One request; inputs are changed just after a falling edge
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input string nm);
    int w = word_of(addr);
    int s = w & 63;
    int t = (w >> 6) & 1023;
    bit exp_hit = m_hit(s, t);
    int exp_cyc = (rd && exp_hit) ? 0 : MISS_CYC;
    int cyc;
    bit saw_rd = 1'b0;
    bit saw_wr = 1'b0;
    logic [31:0] got = 32'd0;
    rd_en = rd;
    wr_en = wr;
    address = addr;
    write_data = wd;
    for (cyc = 0; cyc < 60; cyc++) begin
      #1;
      saw_rd |= sram_rd_en;
      saw_wr |= sram_wr_en;
      if (ready) begin
        got = read_data;
        break;
      end
      @(negedge clk);
    end
    check_eq({nm, "_lat"}, 32'(cyc), 32'(exp_cyc));
    if (rd) begin
      check_eq({nm, "_data"}, got, ref_mem[w]);
      check_eq({nm, "_sram_rd"}, 32'(saw_rd), 32'(!exp_hit));
      check_eq({nm, "_sram_wr"}, 32'(saw_wr), 32'd0);
      m_touch(s, t);
    end else begin
      check_eq({nm, "_sram_wr"}, 32'(saw_wr), 32'd1);
      check_eq({nm, "_sram_rd"}, 32'(saw_rd), 32'd0);
      check_eq({nm, "_wr_rdata"}, got, 32'd0);
      ref_mem[w] = wd;
      if (exp_hit) m_touch(s, t);
    end
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    #1;
    check_eq({nm, "_idle"}, {29'd0, ready, sram_rd_en, sram_wr_en}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < MEM_WORDS; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[0] = 32'hA5A5_0001;
    ref_mem[0]  = 32'hA5A5_0001;
    m_clear();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_ready", 32'(ready), 32'd0);
    check_eq("reset_sram_en", {30'd0, sram_rd_en, sram_wr_en}, 32'd0);
    check_eq("reset_rdata", read_data, 32'd0);

    // Cold miss then same-cycle hit
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, "t1_miss");
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, "t1_hit");

    // Three tags into set 0: tag0 is evicted
    do_req(1'b1, 1'b0, 32'd1280, 32'd0, "t2_rd1280");
    do_req(1'b1, 1'b0, 32'd1536, 32'd0, "t2_rd1536");
    do_req(1'b1, 1'b0, 32'd1280, 32'd0, "t2_hit1280");
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, "t2_miss1024");

    // Write hit updates both SRAM and the cached copy
    do_req(1'b0, 1'b1, 32'd1024, 32'h1234_5678, "t3_wr");
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, "t3_rd");
    check_eq("t3_value", ref_mem[0], 32'h1234_5678);

    // Write miss does not allocate
    do_req(1'b0, 1'b1, 32'd2048, 32'hCAFE_0042, "t4_wr");
    do_req(1'b1, 1'b0, 32'd2048, 32'd0, "t4_rd");

    // Reset in the middle of a read miss
    rd_en = 1'b1;
    address = 32'd1792;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("t5_pre_sram_rd", 32'(sram_rd_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_sram_rd", 32'(sram_rd_en), 32'd0);
    check_eq("t5_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, "t5_rd_after");

    // rd_en and wr_en together on a hit behave as a read hit
    do_req(1'b1, 1'b0, 32'd1280, 32'd0, "t6_fill");
    do_req(1'b1, 1'b1, 32'd1280, 32'hDEAD_BEEF, "t6_both");
    do_req(1'b1, 1'b0, 32'd1280, 32'd0, "t6_reread");

    // Random traffic over a few sets and tags to exercise conflicts
    for (int n = 0; n < 300; n++) begin
      int sel = int'($urandom_range(0, 3));
      int idx = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 5 : 63;
      int tg  = int'($urandom_range(0, 3));
      int op  = int'($urandom_range(0, 99));
      logic [31:0] a = 32'd1024 + (32'((tg << 6) | idx) << 2);
      if (op < 50)      do_req(1'b1, 1'b0, a, 32'd0, "rnd_rd");
      else if (op < 85) do_req(1'b0, 1'b1, a, $urandom, "rnd_wr");
      else              do_req(1'b1, 1'b1, a, $urandom, "rnd_both");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
